// File: rtl/bp_update_scheduler_pkg.sv
// Shared types and helpers for the branch-predictor update scheduler.
package bp_update_scheduler_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_RD = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

  // Entries are packed as {addr, hist, pred}; pred sits at bit 0.
  localparam int pred_lsb = 0;
  localparam int hist_lsb = 1;

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of predicted, unresolved branches. Flush beats push; the
// scheduler never pushes and pops in the same cycle.
module bp_inflight_fifo
  import bp_update_scheduler_pkg::*;
#(
  parameter int width = 6,
  parameter int depth = 4,
  localparam int tw   = clog2(depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [width-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [width-1:0] head,
  output logic [tw-1:0]    wr_ptr
);

  localparam logic [tw:0] full_lvl = (tw + 1)'(depth);

  logic [width-1:0] mem [depth];
  logic [tw-1:0]    rd_ptr;
  logic [tw:0]      count;

  assign full  = (count == full_lvl);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      mem[wr_ptr] <= din;
      wr_ptr      <= wr_ptr + 1'b1;
      count       <= count + 1'b1;
    end else if (pop) begin
      rd_ptr <= rd_ptr + 1'b1;
      count  <= count - 1'b1;
    end
  end

endmodule

// File: rtl/bp_update_scheduler.sv
// Sole owner of the predictor table port: interleaves fetch lookups with
// resolve-time updates and keeps speculative global history consistent.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high; ready never depends on the same channel's valid, and valid may rise
// without waiting for ready.
module bp_update_scheduler
  import bp_update_scheduler_pkg::*;
#(
  parameter int address_width = 1,
  parameter int m             = 4,
  parameter int depth         = 4,
  localparam int tw           = clog2(depth)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [address_width-1:0] req_addr,
  output logic                     req_ready,
  output logic                     pred_valid,
  output logic                     pred_taken,
  output logic [tw-1:0]            pred_tag,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     res_ready,
  output logic                     mispredict,
  output logic [m-1:0]             ghist,
  output logic                     tbl_en,
  output logic                     tbl_we,
  output logic [address_width+m-1:0] tbl_index,
  output logic                     tbl_wtaken,
  input  logic                     tbl_rdata,
  output logic                     dbg_state
);

  localparam int ew       = address_width + m + 1;
  localparam int addr_lsb = hist_lsb + m;

  state_t                   state, state_nxt;
  logic [address_width-1:0] addr_q;
  logic [m-1:0]             snap_q;
  logic                     full, empty;
  logic [ew-1:0]            head;
  logic [tw-1:0]            wr_ptr;
  logic                     res_fire, req_fire, push, flush;
  logic [address_width-1:0] head_addr;
  logic [m-1:0]             head_hist;
  logic                     head_pred;

  assign head_addr = head[addr_lsb +: address_width];
  assign head_hist = head[hist_lsb +: m];
  assign head_pred = head[pred_lsb];
  assign dbg_state = state;

  always_comb begin
    state_nxt  = state;
    res_ready  = 1'b0;
    req_ready  = 1'b0;
    res_fire   = 1'b0;
    req_fire   = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    pred_valid = 1'b0;
    pred_taken = 1'b0;
    pred_tag   = '0;
    tbl_en     = 1'b0;
    tbl_we     = 1'b0;
    tbl_index  = '0;
    tbl_wtaken = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          // Resolve wins the single port; a pending resolve blocks fetch.
          res_ready = !empty;
          res_fire  = res_valid && res_ready;
          req_ready = !full && !res_fire;
          req_fire  = req_valid && req_ready;
          if (res_fire) begin
            tbl_en     = 1'b1;
            tbl_we     = 1'b1;
            tbl_index  = {head_addr, head_hist};
            tbl_wtaken = res_taken;
            flush      = (res_taken != head_pred);
          end else if (req_fire) begin
            tbl_en    = 1'b1;
            tbl_index = {req_addr, ghist};
            state_nxt = WAIT_RD;
          end
        end
        WAIT_RD: begin
          pred_valid = 1'b1;
          pred_taken = tbl_rdata;
          pred_tag   = wr_ptr;
          push       = 1'b1;
          state_nxt  = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ghist      <= '0;
      mispredict <= 1'b0;
      addr_q     <= '0;
      snap_q     <= '0;
    end else begin
      state      <= state_nxt;
      mispredict <= flush;
      if (req_fire) begin
        addr_q <= req_addr;
        snap_q <= ghist;
      end
      if (push) ghist <= {ghist[m-2:0], tbl_rdata};
      else if (flush) ghist <= {head_hist[m-2:0], res_taken};
    end
  end

  bp_inflight_fifo #(
    .width (ew),
    .depth (depth)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (res_fire),
    .flush  (flush),
    .din    ({addr_q, snap_q, tbl_rdata}),
    .full   (full),
    .empty  (empty),
    .head   (head),
    .wr_ptr (wr_ptr)
  );

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler (address_width=1, m=4, depth=4).
module tb_bp_update_scheduler;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [0:0] req_addr;
  logic       req_ready;
  logic       pred_valid;
  logic       pred_taken;
  logic [1:0] pred_tag;
  logic       res_valid;
  logic       res_taken;
  logic       res_ready;
  logic       mispredict;
  logic [3:0] ghist;
  logic       tbl_en;
  logic       tbl_we;
  logic [4:0] tbl_index;
  logic       tbl_wtaken;
  logic       tbl_rdata;
  logic       dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];  // {tag, taken} of predictions still to appear

  bp_update_scheduler #(
    .address_width (1),
    .m             (4),
    .depth         (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .pred_valid (pred_valid),
    .pred_taken (pred_taken),
    .pred_tag   (pred_tag),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .res_ready  (res_ready),
    .mispredict (mispredict),
    .ghist      (ghist),
    .tbl_en     (tbl_en),
    .tbl_we     (tbl_we),
    .tbl_index  (tbl_index),
    .tbl_wtaken (tbl_wtaken),
    .tbl_rdata  (tbl_rdata),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted lookup followed by its prediction cycle.
  task automatic do_req(input logic addr, input logic rdata,
                        input logic [4:0] exp_index, input logic [1:0] exp_tag);
    logic [2:0] e;
    req_valid = 1'b1;
    req_addr  = addr;
    #1;
    check_eq("req_ready", req_ready, 1);
    check_eq("rd_en", tbl_en, 1);
    check_eq("rd_we", tbl_we, 0);
    check_eq("rd_index", tbl_index, exp_index);
    exp_q.push_back({exp_tag, rdata});
    tick();
    req_valid = 1'b0;
    tbl_rdata = rdata;
    #1;
    check_eq("pred_valid", pred_valid, 1);
    check_eq("wait_req_ready", req_ready, 0);
    check_eq("wait_res_ready", res_ready, 0);
    check_eq("wait_state", dbg_state, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("pred_tag", pred_tag, e[2:1]);
      check_eq("pred_taken", pred_taken, e[0]);
    end
    tick();
    tbl_rdata = 1'b0;
    check_eq("pred_pulse_end", pred_valid, 0);
  endtask

  // One accepted resolve; checks the update and the following mispredict flag.
  task automatic do_res(input logic taken, input logic [4:0] exp_index, input logic exp_mis);
    res_valid = 1'b1;
    res_taken = taken;
    #1;
    check_eq("res_ready", res_ready, 1);
    check_eq("wr_en", tbl_en, 1);
    check_eq("wr_we", tbl_we, 1);
    check_eq("wr_index", tbl_index, exp_index);
    check_eq("wr_wtaken", tbl_wtaken, taken);
    check_eq("res_blocks_req", req_ready, 0);
    tick();
    res_valid = 1'b0;
    res_taken = 1'b0;
    #1;
    check_eq("mispredict", mispredict, exp_mis);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = 1'b0;
    res_valid = 1'b0; res_taken = 1'b0; tbl_rdata = 1'b0;

    // Reset state
    tick(); tick();
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_res_ready", res_ready, 0);
    check_eq("rst_tbl_en", tbl_en, 0);
    check_eq("rst_pred_valid", pred_valid, 0);
    check_eq("rst_pred_taken", pred_taken, 0);
    check_eq("rst_pred_tag", pred_tag, 0);
    check_eq("rst_mispredict", mispredict, 0);
    check_eq("rst_ghist", ghist, 0);
    check_eq("rst_tbl_index", tbl_index, 0);
    check_eq("rst_state", dbg_state, 0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_req_ready", req_ready, 1);
    check_eq("post_rst_res_ready", res_ready, 0);
    check_eq("idle_tbl_index", tbl_index, 0);

    // Fill the queue: entries {1,0000,1} {0,0001,1} {1,0011,0} {0,0110,1}
    do_req(1'b1, 1'b1, 5'h10, 2'd0);
    check_eq("ghist_1", ghist, 4'b0001);
    do_req(1'b0, 1'b1, 5'h01, 2'd1);
    check_eq("ghist_2", ghist, 4'b0011);
    do_req(1'b1, 1'b0, 5'h13, 2'd2);
    check_eq("ghist_3", ghist, 4'b0110);
    do_req(1'b0, 1'b1, 5'h06, 2'd3);
    check_eq("ghist_4", ghist, 4'b1101);

    req_valid = 1'b1;
    #1;
    check_eq("full_req_ready", req_ready, 0);
    check_eq("full_tbl_en", tbl_en, 0);
    check_eq("full_res_ready", res_ready, 1);
    req_valid = 1'b0;

    // Correct resolve of {1,0000,1}
    do_res(1'b1, 5'h10, 1'b0);
    check_eq("ghist_keep", ghist, 4'b1101);
    check_eq("unfull_req_ready", req_ready, 1);

    // Fifth request wraps to slot 0
    do_req(1'b1, 1'b0, 5'h1D, 2'd0);
    check_eq("ghist_5", ghist, 4'b1010);

    do_res(1'b1, 5'h01, 1'b0);
    do_res(1'b0, 5'h13, 1'b0);
    check_eq("ghist_keep2", ghist, 4'b1010);

    // Mispredict on {0,0110,1}: flush, repair to {110, 0}
    do_res(1'b0, 5'h06, 1'b1);
    check_eq("flush_res_ready", res_ready, 0);
    check_eq("repair_ghist", ghist, 4'b1100);
    tick();
    check_eq("mispredict_pulse_end", mispredict, 0);

    // Flushed pointers restart at slot 0
    do_req(1'b0, 1'b1, 5'h0C, 2'd0);
    check_eq("ghist_6", ghist, 4'b1001);

    // Simultaneous request and resolve: resolve owns the port
    req_valid = 1'b1; req_addr = 1'b0;
    res_valid = 1'b1; res_taken = 1'b1;
    #1;
    check_eq("both_req_ready", req_ready, 0);
    check_eq("both_res_ready", res_ready, 1);
    check_eq("both_tbl_we", tbl_we, 1);
    check_eq("both_tbl_index", tbl_index, 5'h0C);
    tick();
    res_valid = 1'b0; res_taken = 1'b0;
    #1;
    check_eq("both_mispredict", mispredict, 0);
    check_eq("after_req_ready", req_ready, 1);
    check_eq("after_tbl_index", tbl_index, 5'h09);

    // Reset while the lookup is outstanding
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tbl_rdata = 1'b1;
    #1;
    check_eq("rst_wait_pred_valid", pred_valid, 0);
    check_eq("rst_wait_tbl_en", tbl_en, 0);
    tick();
    rst = 1'b0;
    tbl_rdata = 1'b0;
    #1;
    check_eq("rst_wait_state", dbg_state, 0);
    check_eq("rst_wait_empty", res_ready, 0);
    check_eq("rst_wait_ghist", ghist, 0);
    check_eq("rst_wait_req_ready", req_ready, 1);
    tick();
    check_eq("rst_wait_no_pred", pred_valid, 0);
    check_eq("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
